acumulador_produto: RTL and testbench

- Downstream consumer of the 3x3 unsigned multiplier (5-bit product plus overflow flag).
- Sums a burst of LEN products into a wide accumulator and presents the total with a valid/ready handshake.
- Serves as the accumulate half of a sequential multiply-accumulate path.
- Multiplier output is combinational; this block registers and sequences it.

---
 rtl/acumulador_produto_if.sv | 31 +++
 rtl/acumulador_produto.sv | 117 +++++++++++
 tb/tb_acumulador_produto.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/acumulador_produto_if.sv
// Handshake bundle for acumulador_produto: burst control, the product input
// stream (valid/ready) and the result output stream (valid/ready).
interface acumulador_produto_if #(
  parameter int ACC_W = 10,
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       m;
  logic             ov;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic [LEN_W-1:0] count;

  // Producer of bursts / consumer of results.
  modport master (
    output start, len, abort, in_valid, m, ov, out_ready,
    input  in_ready, out_valid, acc_out, ovf, count
  );

  // The accumulator block itself.
  modport slave (
    input  start, len, abort, in_valid, m, ov, out_ready,
    output in_ready, out_valid, acc_out, ovf, count
  );
endinterface

// File: rtl/acumulador_produto.sv
// acumulador_produto: sums a burst of LEN products {ov, m} from a 3x3
// multiplier into an ACC_W-bit accumulator and presents the total with a
// valid/ready handshake. States: IDLE -> RUN -> DONE -> IDLE.
// Optional macro SATURATE_EN: clamp the accumulator at 2^ACC_W-1 on
// overflow instead of wrapping. The sticky ovf flag is set in both builds.
module acumulador_produto #(
  parameter int ACC_W = 10,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  acumulador_produto_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W:0]   product;
  logic [ACC_W:0]   sum;

  // Product widened to ACC_W+1 so the carry out of the top bit is visible.
  assign product = {{(ACC_W-5){1'b0}}, bus.ov, bus.m};

  // Next-state and datapath update for the three-state burst sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    len_d       = len_q;
    sum         = {1'b0, acc_q} + product;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          if (bus.len != '0) begin
            len_d   = bus.len;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        // abort wins over a simultaneous transfer: nothing is counted.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.in_valid) begin
`ifdef SATURATE_EN
          acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d   = ovf_q | sum[ACC_W];
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.abort || bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_acumulador_produto.sv
// Bench for acumulador_produto (ACC_W=8). Directed bursts push the expected
// total into a scoreboard queue; a monitor pops and compares each time
// out_valid rises. Extra direct checks cover reset, back-pressure, abort
// and the reset-mid-burst case.
module tb_acumulador_produto;

  localparam int ACC_W = 8;
  localparam int LEN_W = 4;
`ifdef SATURATE_EN
  localparam int WRAP_EXP = 255;
`else
  localparam int WRAP_EXP = 38;
`endif

  typedef struct {
    int acc;
    int ovf;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic ov_prev = 1'b0;

  acumulador_produto_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  acumulador_produto #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    bus.start = 1'b1;
    bus.len   = LEN_W'(l);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drive_prod(input logic [5:0] p);
    bus.in_valid = 1'b1;
    bus.m        = p[4:0];
    bus.ov       = p[5];
  endtask

  task automatic send(input logic [5:0] p);
    drive_prod(p);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic push_exp(input int acc, input int ovf, input int cnt);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !ov_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got acc=%0d with empty scoreboard (t=%0t)",
                 bus.acc_out, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_acc", int'(bus.acc_out), e.acc);
        check("result_ovf", int'(bus.ovf), e.ovf);
        check("result_count", int'(bus.count), e.cnt);
      end
    end
    ov_prev <= bus.out_valid;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.m         = '0;
    bus.ov        = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values.
    #3;
    check("rst_acc", int'(bus.acc_out), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three products of 49 (7x7): 147, result one cycle after last transfer.
    push_exp(147, 0, 3);
    do_start(3);
    check("run_in_ready", int'(bus.in_ready), 1);
    drive_prod(6'd49);
    tick();
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("basic_latency_out_valid", int'(bus.out_valid), 1);
    check("basic_done_in_ready", int'(bus.in_ready), 0);
    accept();

    // Back-pressure on input (1,0,0,1) and output (4 stalled cycles).
    push_exp(15, 0, 2);
    do_start(2);
    send(6'd6);
    check("bp_count_v1", int'(bus.count), 1);
    tick();
    check("bp_count_hold1", int'(bus.count), 1);
    tick();
    check("bp_count_hold2", int'(bus.count), 1);
    check("bp_acc_hold", int'(bus.acc_out), 6);
    send(6'd9);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_stall_valid", int'(bus.out_valid), 1);
      check("bp_stall_acc", int'(bus.acc_out), 15);
    end
    accept();
    check("bp_idle_out_valid", int'(bus.out_valid), 0);
    check("bp_idle_acc_kept", int'(bus.acc_out), 15);
    check("bp_idle_count_kept", int'(bus.count), 2);

    // Six products of 49 = 294: wraps to 38 or clamps to 255.
    push_exp(WRAP_EXP, 1, 6);
    do_start(6);
    drive_prod(6'd49);
    for (int i = 0; i < 6; i++) tick();
    bus.in_valid = 1'b0;
    accept();

    // len=0: straight to DONE with a cleared total.
    push_exp(0, 0, 0);
    do_start(0);
    check("len0_out_valid", int'(bus.out_valid), 1);
    accept();

    // start during RUN is ignored.
    push_exp(20, 0, 2);
    do_start(2);
    send(6'd10);
    bus.start = 1'b1;
    bus.len   = 4'd5;
    tick();
    bus.start = 1'b0;
    send(6'd10);
    tick();
    accept();

    // start in the same cycle as the DONE->IDLE handshake is ignored.
    push_exp(7, 0, 1);
    do_start(1);
    send(6'd7);
    bus.start     = 1'b1;
    bus.len       = 4'd3;
    accept();
    bus.start     = 1'b0;
    check("hs_start_ignored_in_ready", int'(bus.in_ready), 0);
    tick();
    check("hs_start_ignored_valid", int'(bus.out_valid), 0);

    // Abort after two transfers while in_valid is still high.
    do_start(5);
    send(6'd3);
    send(6'd3);
    drive_prod(6'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_count", int'(bus.count), 2);
    check("abort_acc", int'(bus.acc_out), 6);
    check("abort_in_ready", int'(bus.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", int'(bus.out_valid), 0);
    end

    // Reset pulsed mid-burst: outputs clear immediately.
    do_start(4);
    send(6'd5);
    send(6'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_acc", int'(bus.acc_out), 0);
    check("midrst_count", int'(bus.count), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
